instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 39 +++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Bundles the fetch-stage control, program-load and output signals
//            shared between instr_fetch and whatever drives it.
// Modports : master - drives stall/redirect/program-load, observes fetch outputs
//            slave  - the fetch stage itself
// Signals  : stall, redirect, redirect_pc[31:0], ld_en, ld_addr[ADDR_W-1:0],
//            ld_data[31:0], instr[31:0], pc[31:0], pc_plus4[31:0],
//            instr_valid, err
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
);
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic [31:0]       instr;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              instr_valid;
  logic              err;

  modport master (
    output stall, redirect, redirect_pc, ld_en, ld_addr, ld_data,
    input  instr, pc, pc_plus4, instr_valid, err
  );

  modport slave (
    input  stall, redirect, redirect_pc, ld_en, ld_addr, ld_data,
    output instr, pc, pc_plus4, instr_valid, err
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage with an internal program memory that is
//            written through a load port. Fetches one word per unstalled
//            cycle, supports redirects (one-cycle bubble) and halts with a
//            sticky error on a misaligned redirect target.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            bus        - instr_fetch_if.slave (stall/redirect/load inputs,
//                         instr/pc/pc_plus4/instr_valid/err outputs)
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  instr_fetch_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fpc, fpc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic        valid_q, valid_nxt;
  logic        err_q, err_nxt;

  // Program memory; deliberately not reset so a program can be loaded while
  // the core is held in reset.
  logic [31:0] mem [MEM_DEPTH];

  // Upper fetch-address bits are ignored: fetch wraps around the memory.
  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       fetch_word;
  assign fetch_idx  = fpc[ADDR_W+1:2];
  assign fetch_word = mem[fetch_idx];

  // The fetch register samples fetch_word at the same edge as this write,
  // so a colliding load/fetch returns the old word.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      fpc     <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      fpc     <= fpc_nxt;
      instr_q <= instr_nxt;
      pc_q    <= pc_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    instr_nxt = instr_q;
    pc_nxt    = pc_q;
    valid_nxt = valid_q;
    err_nxt   = err_q;

    unique case (state)
      BOOT: begin
        // Single settling cycle before the first fetch.
        valid_nxt = 1'b0;
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.redirect) begin
          // Redirect wins over stall; the target is fetched next cycle.
          instr_nxt = 32'h0000_0000;
          valid_nxt = 1'b0;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_nxt = HALT;
            err_nxt   = 1'b1;
          end else begin
            fpc_nxt = bus.redirect_pc;
          end
        end else if (!bus.stall) begin
          instr_nxt = fetch_word;
          pc_nxt    = fpc;
          valid_nxt = 1'b1;
          fpc_nxt   = fpc + 32'd4;
        end
      end
      HALT: begin
        // Terminal until reset.
        instr_nxt = 32'h0000_0000;
        valid_nxt = 1'b0;
        err_nxt   = 1'b1;
      end
      default: begin
        state_nxt = HALT;
        instr_nxt = 32'h0000_0000;
        valid_nxt = 1'b0;
        err_nxt   = 1'b1;
      end
    endcase
  end

  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.instr_valid = valid_q;
  assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. A behavioural model of the
//            fetch stage is compared with the DUT on every falling edge;
//            directed scenarios pin the model with literal expectations,
//            followed by a randomized phase.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  localparam int          DEPTH = 64;
  localparam logic [31:0] W0    = 32'h014B4820;
  localparam logic [31:0] W1    = 32'h014B4824;
  localparam logic [31:0] W2    = 32'h21490005;
  localparam logic [31:0] W3    = 32'h8C430003;
  localparam logic [31:0] W63   = 32'hAC3F00FC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.MEM_DEPTH(DEPTH)) bus ();

  instr_fetch #(.MEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_fpc, m_instr, m_pc;
  logic        m_valid, m_err, m_booting, m_halted;

  always @(posedge clk) begin
    if (bus.ld_en) m_mem[bus.ld_addr] <= bus.ld_data;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fpc     <= 32'h0;
      m_instr   <= 32'h0;
      m_pc      <= 32'h0;
      m_valid   <= 1'b0;
      m_err     <= 1'b0;
      m_booting <= 1'b1;
      m_halted  <= 1'b0;
    end else if (m_booting) begin
      m_booting <= 1'b0;
    end else if (!m_halted) begin
      if (bus.redirect && (bus.redirect_pc % 4 != 0)) begin
        m_halted <= 1'b1;
        m_err    <= 1'b1;
        m_valid  <= 1'b0;
        m_instr  <= 32'h0;
      end else if (bus.redirect) begin
        m_fpc   <= bus.redirect_pc;
        m_instr <= 32'h0;
        m_valid <= 1'b0;
      end else if (!bus.stall) begin
        m_instr <= m_mem[int'((m_fpc / 4) % DEPTH)];
        m_pc    <= m_fpc;
        m_valid <= 1'b1;
        m_fpc   <= m_fpc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    vectors++;
    if (bus.instr_valid !== m_valid || bus.err !== m_err || bus.instr !== m_instr ||
        ((m_valid || rst) && bus.pc !== m_pc) ||
        (m_valid && bus.pc_plus4 !== m_pc + 32'd4)) begin
      miscompares++;
      $display("FAIL cycle_cmp t=%0t: got v=%b e=%b i=%h pc=%h p4=%h expected v=%b e=%b i=%h pc=%h",
               $time, bus.instr_valid, bus.err, bus.instr, bus.pc, bus.pc_plus4,
               m_valid, m_err, m_instr, m_pc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [31:0] e_instr, input logic [31:0] e_pc,
                         input logic e_valid);
    chk({nm, "_instr"}, bus.instr, e_instr);
    chk({nm, "_valid"}, {31'b0, bus.instr_valid}, {31'b0, e_valid});
    if (e_valid) chk({nm, "_pc"}, bus.pc, e_pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = 32'h0;
    #1 rst = 1'b1;

    // Program load under reset.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bus.ld_en   = 1'b1;
      bus.ld_addr = 6'(i);
      case (i)
        0:       bus.ld_data = W0;
        1:       bus.ld_data = W1;
        2:       bus.ld_data = W2;
        3:       bus.ld_data = W3;
        63:      bus.ld_data = W63;
        default: bus.ld_data = $urandom;
      endcase
    end
    @(negedge clk);
    bus.ld_en = 1'b0;
    chk_out("reset", 32'h0, 32'h0, 1'b0);
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_err", {31'b0, bus.err}, 32'h0);
    rst = 1'b0;

    // Boot bubble then sequential fetch.
    @(negedge clk); chk_out("boot", 32'h0, 32'h0, 1'b0);
    @(negedge clk); chk_out("fetch0", W0, 32'h0, 1'b1);
    @(negedge clk); chk_out("fetch1", W1, 32'h4, 1'b1);
    chk("fetch1_pc4", bus.pc_plus4, 32'h8);

    // Stall holds outputs.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_out("stall", W1, 32'h4, 1'b1);
    end
    bus.stall = 1'b0;
    @(negedge clk); chk_out("after_stall", W2, 32'h8, 1'b1);

    // Redirect beats stall.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0; bus.stall = 1'b1;
    @(negedge clk); chk_out("redir_bubble", 32'h0, 32'h0, 1'b0);
    bus.redirect = 1'b0; bus.stall = 1'b0;
    @(negedge clk); chk_out("redir_target", W0, 32'h0, 1'b1);

    // Load colliding with fetch returns the old word.
    bus.redirect = 1'b1; bus.redirect_pc = 32'd12;
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.ld_en = 1'b1; bus.ld_addr = 6'd3; bus.ld_data = 32'hDEADBEEF;
    @(negedge clk); chk_out("rbw_old", W3, 32'd12, 1'b1);
    bus.ld_en = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'd12;
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk); chk_out("rbw_new", 32'hDEADBEEF, 32'd12, 1'b1);

    // Fetch index wraps while pc keeps counting.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_00FC;
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk); chk_out("wrap_last", W63, 32'hFC, 1'b1);
    @(negedge clk); chk_out("wrap_first", W0, 32'h100, 1'b1);
    chk("wrap_pc4", bus.pc_plus4, 32'h104);

    // Misaligned redirect halts with sticky error.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h6;
    @(negedge clk);
    chk_out("halt", 32'h0, 32'h0, 1'b0);
    chk("halt_err", {31'b0, bus.err}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      bus.redirect    = 1'($urandom_range(0, 1));
      bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
      bus.stall       = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_hold_err", {31'b0, bus.err}, 32'h1);
      chk("halt_hold_valid", {31'b0, bus.instr_valid}, 32'h0);
    end
    bus.redirect = 1'b0; bus.stall = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_err", {31'b0, bus.err}, 32'h0);
    chk("async_rst_pc", bus.pc, 32'h0);
    chk_out("async_rst", 32'h0, 32'h0, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); chk_out("reboot", 32'h0, 32'h0, 1'b0);
    @(negedge clk); chk_out("reboot_fetch", W0, 32'h0, 1'b1);

    // Randomized phase, checked by the per-cycle compare.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.stall    = ($urandom_range(0, 99) < 25);
      bus.redirect = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0:       bus.redirect_pc = 32'hFFFF_FFF8;
        1:       bus.redirect_pc = ($urandom & 32'hFFFF_FFFC) | 32'h1;
        2, 3:    bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
        default: bus.redirect_pc = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      endcase
      bus.ld_en   = ($urandom_range(0, 3) == 0);
      bus.ld_addr = 6'($urandom_range(0, DEPTH - 1));
      bus.ld_data = $urandom;
      if ($urandom_range(0, 59) == 0) #2 rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.redirect = 1'b0; bus.stall = 1'b0; bus.ld_en = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
